// File: rtl/sdp_pkg.sv
// sdp_pkg: shared types and constants for the slave data-packet transmit
// controller (sdp_tx_ctrl) and its byte handshake helper (sdp_byte_hs).
// Optional feature macro: SDP_CSUM_EN adds the checksum trailer state.
package sdp_pkg;

`ifdef SDP_CSUM_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PL   = 2'd2,
      ST_TRL  = 2'd3
   } sdp_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PL   = 2'd2
   } sdp_state_e;
`endif

   typedef enum logic {
      KIND_S = 1'b0,
      KIND_D = 1'b1
   } sdp_kind_e;

   // header byte indices
   localparam logic [1:0] HDR_MARKER = 2'd0;
   localparam logic [1:0] HDR_STATUS = 2'd1;
   localparam logic [1:0] HDR_LEN_HI = 2'd2;
   localparam logic [1:0] HDR_LEN_LO = 2'd3;

   // STATUS bit positions; channel occupies [7:ST_BIT_CH_LO]
   localparam int ST_BIT_ERR   = 0;
   localparam int ST_BIT_RDY   = 1;
   localparam int ST_BIT_BUSY  = 2;
   localparam int ST_BIT_DATA  = 4;
   localparam int ST_BIT_CH_LO = 5;

   localparam logic [7:0] SDP_MARKER_SLAVE = 8'hA5;

endpackage

// File: rtl/sdp_byte_hs.sv
// sdp_byte_hs: per-byte handshake toward the channel encoder.
//   Owns the wait flag and its one-cycle guard, qualifies when a byte may be
//   issued, and flags completion of the last byte of a message.
// Ports:
//   clk, n_rst      clock, async active-low reset
//   cd_busy         encoder serialising
//   issue           a byte is strobed to the encoder this cycle
//   issue_last      that byte is the final byte of the message
//   can_issue       a byte may be strobed this cycle
//   done            wait clears after the final byte (message complete)
module sdp_byte_hs (
   input  logic clk,
   input  logic n_rst,
   input  logic cd_busy,
   input  logic issue,
   input  logic issue_last,
   output logic can_issue,
   output logic done
);

   logic wait_q, wait_d;
   logic guard_q, guard_d;
   logic last_q, last_d;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wait_q  <= 1'b0;
         guard_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         wait_q  <= wait_d;
         guard_q <= guard_d;
         last_q  <= last_d;
      end
   end

   // The encoder may not raise cd_busy until the cycle after our strobe, so
   // cd_busy is ignored for one guard cycle after each issue.
   always_comb begin
      wait_d  = wait_q;
      guard_d = 1'b0;
      last_d  = last_q;
      done    = 1'b0;
      if (issue) begin
         wait_d  = 1'b1;
         guard_d = 1'b1;
         last_d  = issue_last;
      end else if (wait_q && !guard_q && !cd_busy) begin
         wait_d = 1'b0;
         done   = last_q;
         last_d = 1'b0;
      end
   end

   assign can_issue = ~cd_busy & ~wait_q;

endmodule

// File: rtl/sdp_tx_ctrl.sv
// sdp_tx_ctrl: slave data-packet transmit controller.
//   On a service/data request emits marker, STATUS, LEN[15:8], LEN[7:0] and,
//   for data packets, DP_LEN payload bytes forwarded from the selected source.
//   One-deep pending request slot; payload suppressed on receive error.
//   SDP_CSUM_EN adds a trailer byte (sum of all bytes after the marker).
// Ports:
//   clk, n_rst                 clock, async active-low reset
//   sd_s_req, sd_d_req         request pulses (data wins if both)
//   ch_sel, rx_err             sampled with the request
//   sd_busy, sd_has_next_dp    live slave status
//   sd_d_tx_rdy                per-source ready
//   sd_d_tx_en                 per-source payload enable
//   sd_d, sd_d_rdy             per-source payload byte and strobe
//   cd_busy                    encoder serialising
//   q, q_rdy                   byte and strobe to encoder
//   msg_end                    end-of-message pulse
//   busy                       message in progress
//
// state | meaning
// IDLE  | waiting for a request or a pending request
// HDR   | issuing header bytes 0..3
// PL    | forwarding payload from source ch_q
// TRL   | issuing the checksum trailer (SDP_CSUM_EN only)
module sdp_tx_ctrl
   import sdp_pkg::*;
#(
   parameter int         N_CH   = 2,
   parameter int         DP_LEN = 64,
   parameter logic [7:0] MARKER = SDP_MARKER_SLAVE,
   localparam int        CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              sd_s_req,
   input  logic              sd_d_req,
   input  logic [CH_W-1:0]   ch_sel,
   input  logic              rx_err,
   input  logic              sd_busy,
   input  logic              sd_has_next_dp,
   input  logic [N_CH-1:0]   sd_d_tx_rdy,
   output logic [N_CH-1:0]   sd_d_tx_en,
   input  logic [N_CH*8-1:0] sd_d,
   input  logic [N_CH-1:0]   sd_d_rdy,
   input  logic              cd_busy,
   output logic [7:0]        q,
   output logic              q_rdy,
   output logic              msg_end,
   output logic              busy
);

   localparam logic [15:0] LEN16 = 16'(DP_LEN);

   sdp_state_e      state_q, state_d;
   logic [1:0]      hdr_cnt_q, hdr_cnt_d;
   logic [15:0]     pl_cnt_q, pl_cnt_d;
   sdp_kind_e       kind_q, kind_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic            err_q, err_d;
   logic            pend_vld_q, pend_vld_d;
   sdp_kind_e       pend_kind_q, pend_kind_d;
   logic [CH_W-1:0] pend_ch_q, pend_ch_d;
   logic            pend_err_q, pend_err_d;
`ifdef SDP_CSUM_EN
   logic [7:0]      csum_q, csum_d;
`endif

   logic        req;
   sdp_kind_e   req_kind;
   logic        can_issue, done, issue, issue_last;
   logic [15:0] len_w;
   logic [7:0]  status, hdr_byte, sel_byte;
   logic        sel_rdy, sel_tx_rdy, pl_en;

   sdp_byte_hs u_hs (
      .clk        (clk),
      .n_rst      (n_rst),
      .cd_busy    (cd_busy),
      .issue      (issue),
      .issue_last (issue_last),
      .can_issue  (can_issue),
      .done       (done)
   );

   assign req      = sd_s_req | sd_d_req;
   assign req_kind = sd_d_req ? KIND_D : KIND_S;
   assign len_w    = (kind_q == KIND_D && !err_q) ? LEN16 : 16'd0;
   assign issue    = q_rdy;
   assign msg_end  = done;
   assign busy     = (state_q != ST_IDLE);

   always_comb begin
      sel_byte   = 8'h00;
      sel_rdy    = 1'b0;
      sel_tx_rdy = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (CH_W'(k) == ch_q) begin
            sel_byte   = sd_d[8*k +: 8];
            sel_rdy    = sd_d_rdy[k];
            sel_tx_rdy = sd_d_tx_rdy[k];
         end
      end
   end

   // STATUS is built from live inputs; it is only meaningful in the cycle
   // byte 1 is issued.
   always_comb begin
      status                 = 8'h00;
      status[ST_BIT_ERR]     = err_q;
      status[ST_BIT_RDY]     = ~err_q & ~sd_busy &
                               ((kind_q == KIND_S) ? sel_tx_rdy : sd_has_next_dp);
      status[ST_BIT_BUSY]    = sd_busy;
      status[ST_BIT_DATA]    = ~err_q & (kind_q == KIND_D);
      status[7:ST_BIT_CH_LO] = 3'(ch_q);
      case (hdr_cnt_q)
         HDR_MARKER: hdr_byte = MARKER;
         HDR_STATUS: hdr_byte = status;
         HDR_LEN_HI: hdr_byte = len_w[15:8];
         default:    hdr_byte = len_w[7:0];
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         hdr_cnt_q   <= 2'd0;
         pl_cnt_q    <= 16'd0;
         kind_q      <= KIND_S;
         ch_q        <= '0;
         err_q       <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_kind_q <= KIND_S;
         pend_ch_q   <= '0;
         pend_err_q  <= 1'b0;
`ifdef SDP_CSUM_EN
         csum_q      <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         hdr_cnt_q   <= hdr_cnt_d;
         pl_cnt_q    <= pl_cnt_d;
         kind_q      <= kind_d;
         ch_q        <= ch_d;
         err_q       <= err_d;
         pend_vld_q  <= pend_vld_d;
         pend_kind_q <= pend_kind_d;
         pend_ch_q   <= pend_ch_d;
         pend_err_q  <= pend_err_d;
`ifdef SDP_CSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      hdr_cnt_d   = hdr_cnt_q;
      pl_cnt_d    = pl_cnt_q;
      kind_d      = kind_q;
      ch_d        = ch_q;
      err_d       = err_q;
      pend_vld_d  = pend_vld_q;
      pend_kind_d = pend_kind_q;
      pend_ch_d   = pend_ch_q;
      pend_err_d  = pend_err_q;
      issue_last  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            hdr_cnt_d = 2'd0;
            pl_cnt_d  = 16'd0;
            if (req) begin
               kind_d     = req_kind;
               ch_d       = ch_sel;
               err_d      = rx_err;
               pend_vld_d = 1'b0;
               state_d    = ST_HDR;
            end else if (pend_vld_q) begin
               kind_d     = pend_kind_q;
               ch_d       = pend_ch_q;
               err_d      = pend_err_q;
               pend_vld_d = 1'b0;
               state_d    = ST_HDR;
            end
         end
         ST_HDR: begin
            if (issue) begin
               if (hdr_cnt_q != HDR_LEN_LO) begin
                  hdr_cnt_d = hdr_cnt_q + 2'd1;
               end else if (len_w != 16'd0) begin
                  state_d = ST_PL;
               end else begin
`ifdef SDP_CSUM_EN
                  state_d = ST_TRL;
`else
                  issue_last = 1'b1;
`endif
               end
            end
         end
         ST_PL: begin
            if (issue) begin
               pl_cnt_d = pl_cnt_q + 16'd1;
               if (pl_cnt_q == LEN16 - 16'd1) begin
`ifdef SDP_CSUM_EN
                  state_d = ST_TRL;
`else
                  issue_last = 1'b1;
`endif
               end
            end
         end
`ifdef SDP_CSUM_EN
         ST_TRL: begin
            if (issue) issue_last = 1'b1;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      if (done) state_d = ST_IDLE;
      // a request during any message (including its msg_end cycle) is parked
      if (state_q != ST_IDLE && req) begin
         pend_vld_d  = 1'b1;
         pend_kind_d = req_kind;
         pend_ch_d   = ch_sel;
         pend_err_d  = rx_err;
      end
   end

`ifdef SDP_CSUM_EN
   // marker and trailer are excluded from the sum
   always_comb begin
      csum_d = csum_q;
      if (state_q == ST_IDLE) begin
         csum_d = 8'h00;
      end else if (issue && state_q != ST_TRL &&
                   !(state_q == ST_HDR && hdr_cnt_q == HDR_MARKER)) begin
         csum_d = csum_q + q;
      end
   end
`endif

   always_comb begin
      q          = 8'h00;
      q_rdy      = 1'b0;
      sd_d_tx_en = '0;
      pl_en      = 1'b0;
      case (state_q)
         ST_HDR: begin
            q_rdy = can_issue;
            if (can_issue) q = hdr_byte;
         end
         ST_PL: begin
            // the counter guard keeps a held-high strobe from leaking a
            // byte past the end of the payload
            pl_en = can_issue & (pl_cnt_q != LEN16);
            for (int k = 0; k < N_CH; k++) begin
               sd_d_tx_en[k] = pl_en & (CH_W'(k) == ch_q);
            end
            q     = sel_byte;
            q_rdy = pl_en & sel_rdy;
         end
`ifdef SDP_CSUM_EN
         ST_TRL: begin
            q_rdy = can_issue;
            if (can_issue) q = csum_q;
         end
`endif
         default: ;
      endcase
   end

endmodule
